// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if: fetch, data and memory-side signals of the unified memory arbiter
interface mips32_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one memory port between fetch and data, data first with starvation guard
module mips32_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    mips32_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic              pick_if, pick_d;
    logic              own_if, we_q, flush_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rbuf, if_hold, d_hold;
    logic [3:0]        cnt;
    logic [SW-1:0]     starve;

    always_comb begin
        pick_if = bus.if_req && (!bus.d_req || starve == SMAX);
        pick_d = bus.d_req && !pick_if;
        state_nxt = state == IDLE ? ((pick_if || pick_d) ? ACCESS : IDLE) :
                    state == ACCESS ? (we_q ? IDLE : WAIT) :
                    state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            own_if <= 1'b0;
            we_q <= 1'b0;
            flush_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rbuf <= '0;
            if_hold <= '0;
            d_hold <= '0;
            cnt <= '0;
            starve <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (pick_if || pick_d) begin
                    own_if <= pick_if;
                    we_q <= pick_d && bus.d_we;
                    addr_q <= pick_if ? bus.if_addr : bus.d_addr;
                    wdata_q <= pick_d ? bus.d_wdata : '0;
                end
                starve <= (!bus.if_req || pick_if) ? '0 :
                          (pick_d && starve != SMAX) ? starve + 1'b1 : starve;
                flush_q <= 1'b0;
            end else begin
                flush_q <= flush_q || (own_if && bus.if_flush);
            end
            cnt <= state == ACCESS ? LAT_M1 : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            // last WAIT cycle is the one in which the memory presents read data
            if (state == WAIT && cnt == 4'd0) rbuf <= bus.mem_rdata;
            if (bus.if_rvalid) if_hold <= rbuf;
            if (bus.d_rvalid) d_hold <= rbuf;
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.mem_en    = state == ACCESS;
    assign bus.mem_we    = bus.mem_en && we_q;
    assign bus.mem_addr  = bus.mem_en ? addr_q : '0;
    assign bus.mem_wdata = bus.mem_we ? wdata_q : '0;
    assign bus.if_gnt    = bus.mem_en && own_if;
    assign bus.d_gnt     = bus.mem_en && !own_if;
    // a flush arriving in the response cycle itself still cancels delivery
    assign bus.if_rvalid = state == RESP && own_if && !flush_q && !bus.if_flush;
    assign bus.d_rvalid  = state == RESP && !own_if;
    assign bus.if_rdata  = bus.if_rvalid ? rbuf : if_hold;
    assign bus.d_rdata   = bus.d_rvalid ? rbuf : d_hold;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed vector bench for the unified memory arbiter
module tb_mips32_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b2 ();
    mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b1 ();
    mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b15 ();

    mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(3))
        dut (.clk(clk), .rst_n(rst_n), .bus(b2));
    mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(15), .STARVE_MAX(3))
        u15 (.clk(clk), .rst_n(rst_n), .bus(b15));

    function automatic logic [31:0] f(input logic [9:0] a);
        return 32'hC0DE0000 | {22'd0, a};
    endfunction

    // memory models: read data is valid only in the cycle exactly LAT after mem_en
    logic [31:0] mem [1024];
    logic [4:0]  k2, k1, k15;
    logic [9:0]  a2, a1, a15;

    always @(posedge clk) begin
        if (!rst_n) begin
            k2 <= 5'd0;
            k1 <= 5'd0;
            k15 <= 5'd0;
            for (int i = 0; i < 1024; i++) mem[i] <= f(10'(i));
        end else begin
            if (b2.mem_en && b2.mem_we) mem[b2.mem_addr] <= b2.mem_wdata;
            if (b2.mem_en && !b2.mem_we) begin k2 <= 5'd1; a2 <= b2.mem_addr; end
            else k2 <= (k2 != 5'd0 && k2 < 5'd2) ? k2 + 5'd1 : 5'd0;
            if (b1.mem_en && !b1.mem_we) begin k1 <= 5'd1; a1 <= b1.mem_addr; end
            else k1 <= 5'd0;
            if (b15.mem_en && !b15.mem_we) begin k15 <= 5'd1; a15 <= b15.mem_addr; end
            else k15 <= (k15 != 5'd0 && k15 < 5'd15) ? k15 + 5'd1 : 5'd0;
        end
    end

    assign b2.mem_rdata  = (k2 == 5'd2) ? mem[a2] : 32'hBAD0BAD0;
    assign b1.mem_rdata  = (k1 == 5'd1) ? f(a1) : 32'hBAD0BAD0;
    assign b15.mem_rdata = (k15 == 5'd15) ? f(a15) : 32'hBAD0BAD0;

    typedef struct {
        logic        ir;
        logic [9:0]  ia;
        logic        fl;
        logic        dr;
        logic        dw;
        logic [9:0]  da;
        logic [31:0] dd;
        logic [6:0]  eo;
        logic [31:0] erd;
    } vec_t;

    // expected {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_IG   = 7'b1000101;
    localparam logic [6:0] O_DGR  = 7'b0100101;
    localparam logic [6:0] O_DGW  = 7'b0100111;
    localparam logic [6:0] O_BUSY = 7'b0000001;
    localparam logic [6:0] O_IRV  = 7'b0010001;
    localparam logic [6:0] O_DRV  = 7'b0001001;

    function automatic vec_t mk(input logic ir, input logic [9:0] ia, input logic fl,
                                input logic dr, input logic dw, input logic [9:0] da,
                                input logic [31:0] dd, input logic [6:0] eo, input logic [31:0] erd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.fl = fl; v.dr = dr; v.dw = dw;
        v.da = da; v.dd = dd; v.eo = eo; v.erd = erd;
        return v;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs2();
        return {25'd0, b2.if_gnt, b2.d_gnt, b2.if_rvalid, b2.d_rvalid, b2.mem_en, b2.mem_we, b2.busy};
    endfunction

    vec_t tv[$];
    vec_t v;
    int   g1, g15, r1, r15;
    logic [31:0] d1, d15;
    logic seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        {b2.if_req, b2.if_addr, b2.if_flush, b2.d_req, b2.d_we, b2.d_addr, b2.d_wdata} = '0;
        {b1.if_req, b1.if_addr, b1.if_flush, b1.d_req, b1.d_we, b1.d_addr, b1.d_wdata} = '0;
        {b15.if_req, b15.if_addr, b15.if_flush, b15.d_req, b15.d_we, b15.d_addr, b15.d_wdata} = '0;

        // fetch 0x010: gnt at t+1, rvalid at t+4
        tv.push_back(mk(1, 10'h010, 0, 0, 0, 0, 0, O_IDLE, 0));
        tv.push_back(mk(1, 10'h010, 0, 0, 0, 0, 0, O_IG, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IRV, 32'hC0DE0010));
        // store then load back 0x020
        tv.push_back(mk(0, 0, 0, 1, 1, 10'h020, 32'hDEADBEEF, O_IDLE, 0));
        tv.push_back(mk(0, 0, 0, 1, 1, 10'h020, 32'hDEADBEEF, O_DGW, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 10'h020, 0, O_IDLE, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 10'h020, 0, O_DGR, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_DRV, 32'hDEADBEEF));
        // both held: data, data, data, fetch, data
        for (int k = 0; k < 5; k++) begin
            tv.push_back(mk(1, 10'h030, 0, 1, 0, 10'h040, 0, O_IDLE, 0));
            tv.push_back(mk(1, 10'h030, 0, 1, 0, 10'h040, 0, k == 3 ? O_IG : O_DGR, 0));
            tv.push_back(mk(1, 10'h030, 0, 1, 0, 10'h040, 0, O_BUSY, 0));
            tv.push_back(mk(1, 10'h030, 0, 1, 0, 10'h040, 0, O_BUSY, 0));
            tv.push_back(mk(1, 10'h030, 0, 1, 0, 10'h040, 0, k == 3 ? O_IRV : O_DRV,
                            k == 3 ? 32'hC0DE0030 : 32'hC0DE0040));
        end
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE, 0));
        // fetch flushed in WAIT, then a load with flush asserted (no effect)
        tv.push_back(mk(1, 10'h050, 0, 0, 0, 0, 0, O_IDLE, 0));
        tv.push_back(mk(1, 10'h050, 0, 0, 0, 0, 0, O_IG, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 10'h060, 0, O_IDLE, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 10'h060, 0, O_DGR, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, O_DRV, 32'hC0DE0060));
        // flush only in the response cycle
        tv.push_back(mk(1, 10'h070, 0, 0, 0, 0, 0, O_IDLE, 0));
        tv.push_back(mk(1, 10'h070, 0, 0, 0, 0, 0, O_IG, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, O_BUSY, 0));
        // flush in IDLE alongside the request is ignored
        tv.push_back(mk(1, 10'h080, 1, 0, 0, 0, 0, O_IDLE, 0));
        tv.push_back(mk(1, 10'h080, 0, 0, 0, 0, 0, O_IG, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_BUSY, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IRV, 32'hC0DE0080));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset outs", outs2(), 0);
        chk("reset if_rdata", b2.if_rdata, 0);
        chk("reset d_rdata", b2.d_rdata, 0);
        chk("reset mem_addr", {22'd0, b2.mem_addr}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            @(posedge clk);
            #1;
            b2.if_req = v.ir; b2.if_addr = v.ia; b2.if_flush = v.fl;
            b2.d_req = v.dr; b2.d_we = v.dw; b2.d_addr = v.da; b2.d_wdata = v.dd;
            @(negedge clk);
            chk($sformatf("row%0d outs", i), outs2(), {25'd0, v.eo});
            if (v.eo[4]) chk($sformatf("row%0d if_rdata", i), b2.if_rdata, v.erd);
            if (v.eo[3]) chk($sformatf("row%0d d_rdata", i), b2.d_rdata, v.erd);
            if (v.eo[2]) chk($sformatf("row%0d mem_addr", i), {22'd0, b2.mem_addr},
                             {22'd0, v.eo[6] ? v.ia : v.da});
            chk($sformatf("row%0d mem_wdata", i), b2.mem_wdata, v.eo[1] ? v.dd : 32'd0);
        end
        chk("hold if_rdata", b2.if_rdata, 32'hC0DE0080);
        chk("hold d_rdata", b2.d_rdata, 32'hC0DE0060);

        // reset during WAIT of a load
        @(posedge clk);
        #1;
        b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 10'h020;
        @(posedge clk);
        #1;
        b2.d_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst pre busy", {31'd0, b2.busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst outs", outs2(), 0);
        chk("rst d_rdata", b2.d_rdata, 0);
        chk("rst if_rdata", b2.if_rdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (b2.d_rvalid || b2.busy || b2.mem_en) seen = 1'b1;
        end
        chk("rst no response", {31'd0, seen}, 0);

        // latency of MEM_LAT=1 and MEM_LAT=15 builds
        g1 = -1; g15 = -1; r1 = -1; r15 = -1; d1 = '0; d15 = '0;
        @(posedge clk);
        #1;
        b1.if_req = 1'b1; b1.if_addr = 10'h0AB;
        b15.if_req = 1'b1; b15.if_addr = 10'h0CD;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (b1.if_gnt) begin if (g1 < 0) g1 = c; b1.if_req = 1'b0; end
            if (b15.if_gnt) begin if (g15 < 0) g15 = c; b15.if_req = 1'b0; end
            if (b1.if_rvalid && r1 < 0) begin r1 = c; d1 = b1.if_rdata; end
            if (b15.if_rvalid && r15 < 0) begin r15 = c; d15 = b15.if_rdata; end
        end
        chk("lat1 gnt cycle", g1, 1);
        chk("lat15 gnt cycle", g15, 1);
        chk("lat1 rvalid cycle", r1, 3);
        chk("lat15 rvalid cycle", r15, 17);
        chk("lat1 data", d1, 32'hC0DE00AB);
        chk("lat15 data", d15, 32'hC0DE00CD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
